// File: rtl/router_pkg.sv
// ============================================================================
// router_pkg : shared types, default sizes and helpers for the router output
//              port arbiter.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package router_pkg;

  localparam int DEF_NUM_IPORT = 4;
  localparam int DEF_NUM_OPORT = 4;
  localparam int ADDR_W        = $clog2(DEF_NUM_OPORT);
  localparam int ISEL_W        = $clog2(DEF_NUM_IPORT);

  typedef logic [ISEL_W-1:0] iport_idx_t;
  typedef logic [ADDR_W-1:0] oport_idx_t;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } arb_state_t;

  // Round-robin successor of idx in a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/router_rr_pick.sv
// ============================================================================
// router_rr_pick : combinational N-way round-robin picker; first candidate
//                  at or after i_ptr, wrapping.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module router_rr_pick
  import router_pkg::*;
#(
  parameter  int N  = DEF_NUM_IPORT,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_cand,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_win,
  output logic [IW-1:0] o_win_idx,
  output logic          o_any
);

  logic found;

  always_comb begin
    found     = 1'b0;
    o_win     = '0;
    o_win_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && i_cand[(int'(i_ptr) + k) % N]) begin
        found                          = 1'b1;
        o_win[(int'(i_ptr) + k) % N]   = 1'b1;
        o_win_idx                      = IW'((int'(i_ptr) + k) % N);
      end
    end
    o_any = found;
  end

endmodule

`default_nettype wire

// File: rtl/router_oport_arbiter.sv
// ============================================================================
// router_oport_arbiter : per-output round-robin ownership arbiter driving the
//                        crossbar selects. Optional ROUTER_ARB_WATCHDOG_EN
//                        forces release after WDOG_MAX owned cycles.
// Revision             : 1.0
// ============================================================================
`default_nettype none

module router_oport_arbiter
  import router_pkg::*;
#(
  parameter int NUM_IPORT = DEF_NUM_IPORT,
  parameter int NUM_OPORT = DEF_NUM_OPORT
`ifdef ROUTER_ARB_WATCHDOG_EN
  ,
  parameter int WDOG_MAX  = 1024
`endif
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [NUM_IPORT-1:0]                     i_req,
  input  logic [NUM_IPORT*$clog2(NUM_OPORT)-1:0]   i_dst_addr,
  input  logic [NUM_IPORT-1:0]                     i_frame,
  output logic [NUM_IPORT-1:0]                     o_gnt,
  output logic [NUM_OPORT*$clog2(NUM_IPORT)-1:0]   o_sel,
  output logic [NUM_OPORT-1:0]                     o_sel_vld,
  output logic                                     o_wdog_err
);

  localparam int DST_W = $clog2(NUM_OPORT);
  localparam int IDX_W = $clog2(NUM_IPORT);

  arb_state_t           state_q [NUM_OPORT];
  arb_state_t           state_d [NUM_OPORT];
  logic [IDX_W-1:0]     owner_q [NUM_OPORT];
  logic [IDX_W-1:0]     owner_d [NUM_OPORT];
  logic [IDX_W-1:0]     ptr_q   [NUM_OPORT];
  logic [IDX_W-1:0]     ptr_d   [NUM_OPORT];
  logic [NUM_IPORT-1:0] cand    [NUM_OPORT];
  logic [NUM_IPORT-1:0] win     [NUM_OPORT];
  logic [IDX_W-1:0]     win_idx [NUM_OPORT];
  logic [NUM_OPORT-1:0] pick_any;
  logic [NUM_OPORT-1:0] wdog_hit;
  logic [NUM_IPORT-1:0] excl;

  logic [NUM_IPORT-1:0]       gnt_q, gnt_d;
  logic [NUM_OPORT*IDX_W-1:0] sel_q, sel_d;
  logic [NUM_OPORT-1:0]       vld_q, vld_d;

  // An input already granted anywhere can never contend, so it owns at most one output.
  always_comb begin
    for (int o = 0; o < NUM_OPORT; o++) begin
      for (int i = 0; i < NUM_IPORT; i++) begin
        cand[o][i] = i_req[i] && !gnt_q[i] && !excl[i] &&
                     (i_dst_addr[i*DST_W +: DST_W] == DST_W'(o));
      end
    end
  end

  for (genvar g = 0; g < NUM_OPORT; g++) begin : g_pick
    router_rr_pick #(.N(NUM_IPORT)) u_pick (
      .i_cand    (cand[g]),
      .i_ptr     (ptr_q[g]),
      .o_win     (win[g]),
      .o_win_idx (win_idx[g]),
      .o_any     (pick_any[g])
    );
  end

  always_comb begin
    gnt_d = '0;
    vld_d = '0;
    sel_d = sel_q;
    for (int o = 0; o < NUM_OPORT; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      case (state_q[o])
        S_IDLE: begin
          if (pick_any[o]) begin
            state_d[o] = S_OWNED;
            owner_d[o] = win_idx[o];
            gnt_d      = gnt_d | win[o];
          end
        end
        default: begin
          if (!i_frame[owner_q[o]] || wdog_hit[o]) begin
            state_d[o] = S_IDLE;
            ptr_d[o]   = IDX_W'(rr_next(int'(unsigned'(owner_q[o])), NUM_IPORT));
          end else begin
            gnt_d[owner_q[o]] = 1'b1;
          end
        end
      endcase
      vld_d[o]                  = (state_d[o] == S_OWNED);
      sel_d[o*IDX_W +: IDX_W]   = owner_d[o];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q <= '0;
      sel_q <= '0;
      vld_q <= '0;
      for (int o = 0; o < NUM_OPORT; o++) begin
        state_q[o] <= S_IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      gnt_q <= gnt_d;
      sel_q <= sel_d;
      vld_q <= vld_d;
      for (int o = 0; o < NUM_OPORT; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

  assign o_gnt     = gnt_q;
  assign o_sel     = sel_q;
  assign o_sel_vld = vld_q;

`ifdef ROUTER_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(WDOG_MAX + 1);

  logic [CNT_W-1:0]     wcnt_q [NUM_OPORT];
  logic [CNT_W-1:0]     wcnt_d [NUM_OPORT];
  logic [NUM_IPORT-1:0] blk_q, blk_d;
  logic                 wdog_q;

  // A frame ending in the same cycle is a normal release, not a watchdog event.
  always_comb begin
    blk_d = blk_q;
    for (int o = 0; o < NUM_OPORT; o++) begin
      wdog_hit[o] = (state_q[o] == S_OWNED) && i_frame[owner_q[o]] &&
                    (wcnt_q[o] == CNT_W'(WDOG_MAX - 1));
      wcnt_d[o]   = (state_q[o] == S_OWNED) ? wcnt_q[o] + CNT_W'(1) : '0;
      if (wdog_hit[o]) begin
        blk_d[owner_q[o]] = 1'b1;
      end
    end
    blk_d = blk_d & i_frame;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_q  <= '0;
      wdog_q <= 1'b0;
      for (int o = 0; o < NUM_OPORT; o++) begin
        wcnt_q[o] <= '0;
      end
    end else begin
      blk_q  <= blk_d;
      wdog_q <= |wdog_hit;
      for (int o = 0; o < NUM_OPORT; o++) begin
        wcnt_q[o] <= wcnt_d[o];
      end
    end
  end

  assign excl       = blk_q;
  assign o_wdog_err = wdog_q;
`else
  assign wdog_hit   = '0;
  assign excl       = '0;
  assign o_wdog_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_router_oport_arbiter.sv
// ============================================================================
// tb_router_oport_arbiter : directed checks of grant latency, round-robin
//                           order, parallel grants, release and async reset.
// Revision                : 1.0
// ============================================================================
`default_nettype none

module tb_router_oport_arbiter;
  import router_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] i_req;
  logic [7:0] i_dst_addr;
  logic [3:0] i_frame;
  logic [3:0] o_gnt;
  logic [7:0] o_sel;
  logic [3:0] o_sel_vld;
  logic       o_wdog_err;

  int checks   = 0;
  int failures = 0;
  int order [4] = '{0, 1, 3, 0};

  always #5 clk = ~clk;

  router_oport_arbiter #(
    .NUM_IPORT (4),
    .NUM_OPORT (4)
`ifdef ROUTER_ARB_WATCHDOG_EN
    ,
    .WDOG_MAX  (8)
`endif
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_req      (i_req),
    .i_dst_addr (i_dst_addr),
    .i_frame    (i_frame),
    .o_gnt      (o_gnt),
    .o_sel      (o_sel),
    .o_sel_vld  (o_sel_vld),
    .o_wdog_err (o_wdog_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic req, input logic [1:0] dst, input logic frm);
    i_req[i]          = req;
    i_dst_addr[i*2+:2] = dst;
    i_frame[i]        = frm;
  endtask

  task automatic clear_in();
    i_req      = '0;
    i_dst_addr = '0;
    i_frame    = '0;
  endtask

  task automatic do_reset();
    clear_in();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    clear_in();
    tick();
    chk("rst_gnt", o_gnt, 4'h0);
    chk("rst_vld", o_sel_vld, 4'h0);
    chk("rst_sel", o_sel, 8'h00);
    chk("rst_wdog", o_wdog_err, 1'b0);
    tick();
    reset_n = 1'b1;

    // Single request: one-cycle grant latency, one-cycle release.
    set_in(0, 1'b1, 2'd2, 1'b1);
    chk("single_lat0", o_gnt, 4'h0);
    tick();
    chk("single_gnt", o_gnt, 4'b0001);
    chk("single_vld", o_sel_vld, 4'b0100);
    chk("single_sel", o_sel[5:4], 2'd0);
    for (int c = 0; c < 8; c++) tick();
    chk("single_hold", o_gnt, 4'b0001);
    set_in(0, 1'b0, 2'd2, 1'b0);
    tick();
    chk("single_rel_gnt", o_gnt, 4'h0);
    chk("single_rel_vld", o_sel_vld, 4'h0);

    // Contention on output 1: round-robin order 0,1,3,0.
    do_reset();
    set_in(0, 1'b1, 2'd1, 1'b1);
    set_in(1, 1'b1, 2'd1, 1'b1);
    set_in(3, 1'b1, 2'd1, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("rr_gnt", o_gnt, 32'(1) << order[k]);
      chk("rr_sel", o_sel[3:2], 32'(order[k]));
      chk("rr_vld", o_sel_vld, 4'b0010);
      tick();
      chk("rr_hold", o_gnt, 32'(1) << order[k]);
      i_frame[order[k]] = 1'b0;
      tick();
      chk("rr_rel", o_gnt, 4'h0);
      i_frame[order[k]] = 1'b1;
      tick();
    end

    // Parallel grants to distinct outputs.
    do_reset();
    for (int i = 0; i < 4; i++) set_in(i, 1'b1, 2'(i), 1'b1);
    chk("par_lat0", o_gnt, 4'h0);
    tick();
    chk("par_gnt", o_gnt, 4'hF);
    chk("par_vld", o_sel_vld, 4'hF);
    chk("par_sel", o_sel, 8'hE4);

    // Back-to-back handover on output 0 (its pointer now sits at 1).
    clear_in();
    tick();
    chk("b2b_idle", o_gnt, 4'h0);
    set_in(2, 1'b1, 2'd0, 1'b1);
    tick();
    chk("b2b_gnt2", o_gnt, 4'b0100);
    chk("b2b_sel2", o_sel[1:0], 2'd2);
    set_in(1, 1'b1, 2'd0, 1'b1);
    tick();
    chk("b2b_wait", o_gnt, 4'b0100);
    set_in(2, 1'b0, 2'd0, 1'b0);
    tick();
    chk("b2b_m1_gnt", o_gnt, 4'h0);
    chk("b2b_m1_vld", o_sel_vld, 4'h0);
    chk("b2b_sel_hold", o_sel[1:0], 2'd2);
    tick();
    chk("b2b_m2_gnt", o_gnt, 4'b0010);
    chk("b2b_m2_sel", o_sel[1:0], 2'd1);
    i_dst_addr[3:2] = 2'd3;
    tick();
    chk("dst_ignored_gnt", o_gnt, 4'b0010);
    chk("dst_ignored_vld", o_sel_vld, 4'b0001);

    // Asynchronous reset mid-frame, away from any clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_gnt", o_gnt, 4'h0);
    chk("async_vld", o_sel_vld, 4'h0);
    clear_in();
    tick();
    tick();
    reset_n = 1'b1;
    set_in(0, 1'b1, 2'd0, 1'b1);
    set_in(3, 1'b1, 2'd0, 1'b1);
    tick();
    chk("post_rst_gnt", o_gnt, 4'b0001);
    chk("post_rst_sel", o_sel[1:0], 2'd0);

`ifdef ROUTER_ARB_WATCHDOG_EN
    // Watchdog forces release after 8 owned cycles; the waiter takes over.
    do_reset();
    set_in(0, 1'b1, 2'd1, 1'b1);
    tick();
    chk("wd_gnt0", o_gnt, 4'b0001);
    set_in(2, 1'b1, 2'd1, 1'b1);
    for (int c = 0; c < 7; c++) begin
      tick();
      chk("wd_hold", o_gnt, 4'b0001);
      chk("wd_noerr", o_wdog_err, 1'b0);
    end
    tick();
    chk("wd_rel_gnt", o_gnt, 4'h0);
    chk("wd_err", o_wdog_err, 1'b1);
    tick();
    chk("wd_err_pulse", o_wdog_err, 1'b0);
    chk("wd_next_gnt", o_gnt, 4'b0100);
    chk("wd_next_sel", o_sel[3:2], 2'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
